jtgng_unamiga_romload: RTL and testbench

//  ROM download writer, directly downstream of the SD-card/SPI loader.

---
 rtl/jtgng_unamiga_romload.sv | 170 +++++++++++++++++
 tb/tb_jtgng_unamiga_romload.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_unamiga_romload.sv
// ROM download writer: packs the loader byte stream into 16-bit words,
// queues them in a small FIFO and hands them to the SDRAM controller
// through a req/ack handshake. Signals completion once all words are written.
//
// Ports:
//   clk_rom, rst_n                  clock, async active-low reset
//   downloading                     loader is streaming bytes
//   ioctl_addr/ioctl_data/ioctl_wr  byte address, byte, byte-valid strobe
//   sdram_req/addr/din/dqm          head FIFO word presented to the SDRAM
//   sdram_ack                       head word written, pop it
//   prog_done                       one-cycle pulse when the download is committed
//   busy                            download in progress
//   overflow                        sticky: a word was dropped on a full FIFO
module jtgng_unamiga_romload #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 22
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic          sdram_req,
  output logic [AW-2:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_dqm,
  input  logic          sdram_ack,
  output logic          prog_done,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = AW - 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t state, state_nx;

  // pending (not yet paired) byte
  logic           pend_valid, pend_valid_nx;
  logic           pend_hi, pend_hi_nx;
  logic [WAW-1:0] pend_waddr, pend_waddr_nx;
  logic [7:0]     pend_data, pend_data_nx;

  // FIFO storage and pointers
  logic [WAW-1:0] mem_addr [DEPTH];
  logic [15:0]    mem_din  [DEPTH];
  logic [1:0]     mem_dqm  [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;

  logic           push, pop, do_write, differs, load_start;
  logic [WAW-1:0] push_addr;
  logic [15:0]    push_din;
  logic [1:0]     push_dqm;

  // state register
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (downloading) state_nx = LOAD;
      LOAD:    if (!downloading) state_nx = FLUSH;
      FLUSH: begin
        if (downloading) state_nx = LOAD;
        else if (!pend_valid && count == '0) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign load_start = (state != LOAD) && (state_nx == LOAD);

  // byte packing: decides the word to push and the new pending byte
  always_comb begin
    pend_valid_nx = pend_valid;
    pend_hi_nx    = pend_hi;
    pend_waddr_nx = pend_waddr;
    pend_data_nx  = pend_data;
    push          = 1'b0;
    differs       = 1'b0;
    push_addr     = pend_waddr;
    push_din      = pend_hi ? {pend_data, 8'h00} : {8'h00, pend_data};
    push_dqm      = pend_hi ? 2'b01 : 2'b10;
    if (state == LOAD && ioctl_wr) begin
      differs = pend_valid && (pend_waddr != ioctl_addr[AW-1:1]);
      if (differs) push = 1'b1;  // partial word from the stale pending byte
      if (!ioctl_addr[0]) begin
        pend_valid_nx = 1'b1;
        pend_hi_nx    = 1'b0;
        pend_waddr_nx = ioctl_addr[AW-1:1];
        pend_data_nx  = ioctl_data;
      end else if (pend_valid && !differs && !pend_hi) begin
        push          = 1'b1;
        push_addr     = ioctl_addr[AW-1:1];
        push_din      = {ioctl_data, pend_data};
        push_dqm      = 2'b00;
        pend_valid_nx = 1'b0;
      end else begin
        pend_valid_nx = 1'b1;
        pend_hi_nx    = 1'b1;
        pend_waddr_nx = ioctl_addr[AW-1:1];
        pend_data_nx  = ioctl_data;
      end
    end else if (state == FLUSH && pend_valid) begin
      push          = 1'b1;
      pend_valid_nx = 1'b0;
    end
  end

  assign pop      = sdram_ack && (count != '0);
  assign do_write = push && ((count != CW'(DEPTH)) || pop);

  // pending byte, FIFO pointers and overflow flag
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_hi    <= 1'b0;
      pend_waddr <= '0;
      pend_data  <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else if (load_start) begin
      pend_valid <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_valid <= pend_valid_nx;
      pend_hi    <= pend_hi_nx;
      pend_waddr <= pend_waddr_nx;
      pend_data  <= pend_data_nx;
      if (do_write) wptr <= wptr + PW'(1);
      if (pop)      rptr <= rptr + PW'(1);
      if (do_write && !pop)      count <= count + CW'(1);
      else if (!do_write && pop) count <= count - CW'(1);
      if (push && !do_write) overflow <= 1'b1;
    end
  end

  // FIFO storage, no reset needed: validity is tracked by count
  always_ff @(posedge clk_rom) begin
    if (do_write && !load_start) begin
      mem_addr[wptr] <= push_addr;
      mem_din[wptr]  <= push_din;
      mem_dqm[wptr]  <= push_dqm;
    end
  end

  // outputs decoded straight from registers
  assign sdram_req  = (count != '0);
  assign sdram_addr = mem_addr[rptr];
  assign sdram_din  = mem_din[rptr];
  assign sdram_dqm  = mem_dqm[rptr];
  assign prog_done  = (state == DONE);
  assign busy       = (state == LOAD) || (state == FLUSH);

endmodule

// File: tb/tb_jtgng_unamiga_romload.sv
// Self-checking bench for jtgng_unamiga_romload: directed scenarios plus
// randomized downloads compared against a word-grouping reference model.
module tb_jtgng_unamiga_romload;

  localparam int unsigned AW    = 22;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [AW-2:0] a;
    logic [15:0]   d;
    logic [1:0]    m;
  } wr_t;

  logic          clk_rom = 1'b0;
  logic          rst_n;
  logic          downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          sdram_req;
  logic [AW-2:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_dqm;
  logic          sdram_ack;
  logic          prog_done;
  logic          busy;
  logic          overflow;

  jtgng_unamiga_romload #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_dqm   (sdram_dqm),
    .sdram_ack   (sdram_ack),
    .prog_done   (prog_done),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk_rom = ~clk_rom;

  int  checks = 0;
  int  errors = 0;
  int  ack_lat;
  bit  ack_en;
  int  wcnt;
  int  done_cnt;
  bit  prev_held;
  wr_t prev_head;
  wr_t exp_q[$];
  wr_t got_q[$];
  int  q_addr[$];
  int  q_data[$];

  // one clock: sample outputs, act as SDRAM responder, drive loader inputs
  task automatic step(input bit wr, input int a, input int d);
    wr_t head;
    @(negedge clk_rom);
    head = {sdram_addr, sdram_din, sdram_dqm};
    if (prog_done === 1'b1) begin
      done_cnt++;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL busy_at_done got %b want 0", busy);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL done_early writes %0d want %0d", got_q.size(), exp_q.size());
      end
    end
    if (sdram_req === 1'b1) begin
      if (prev_held) begin
        checks++;
        if (head !== prev_head) begin
          errors++; $display("FAIL head_stable got %h want %h", head, prev_head);
        end
      end
      wcnt++;
      if (ack_en && wcnt >= ack_lat) begin
        sdram_ack = 1'b1; got_q.push_back(head); wcnt = 0; prev_held = 1'b0;
      end else begin
        sdram_ack = 1'b0; prev_held = 1'b1; prev_head = head;
      end
    end else begin
      sdram_ack = 1'b0; wcnt = 0; prev_held = 1'b0;
    end
    ioctl_wr   = wr;
    ioctl_addr = AW'(a);
    ioctl_data = 8'(d);
  endtask

  // reference model: bytes grouped by word address, missing halves masked
  task automatic build_exp();
    int i;
    int w;
    bit lo_v, hi_v;
    logic [7:0] lo, hi;
    exp_q.delete();
    i = 0;
    while (i < q_addr.size()) begin
      w = q_addr[i] / 2;
      lo_v = 0; hi_v = 0; lo = 8'h00; hi = 8'h00;
      while (i < q_addr.size() && q_addr[i] / 2 == w) begin
        if (q_addr[i] % 2 == 1) begin hi_v = 1; hi = 8'(q_data[i]); end
        else                    begin lo_v = 1; lo = 8'(q_data[i]); end
        i++;
      end
      exp_q.push_back({(AW-1)'(w), hi, lo, ~hi_v, ~lo_v});
    end
  endtask

  // full download of q_addr/q_data; acks withheld for the first stall_bytes bytes
  task automatic run_download(input string name, input int lat, input int stall_bytes,
                              input int max_gap, input bit exp_ovf);
    int g;
    int n;
    got_q.delete();
    done_cnt = 0; ack_lat = lat; ack_en = (stall_bytes == 0); wcnt = 0; prev_held = 0;
    downloading = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < q_addr.size(); i++) begin
      if (i == stall_bytes) ack_en = 1'b1;
      step(1, q_addr[i], q_data[i]);
      g = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1));
      repeat (g) step(0, 0, 0);
    end
    step(0, 0, 0); step(0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_load got %b want 1", name, busy); end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++; $display("FAIL %s overflow_load got %b want %b", name, overflow, exp_ovf);
    end
    ack_en = 1'b1;
    downloading = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 400) begin step(0, 0, 0); n++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL %s done_timeout got 0 pulses want 1", name); end
    repeat (6) step(0, 0, 0);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s write_count got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write%0d got a=%h d=%h m=%b want a=%h d=%h m=%b", name, i,
                 got_q[i].a, got_q[i].d, got_q[i].m, exp_q[i].a, exp_q[i].d, exp_q[i].m);
      end
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++; $display("FAIL %s overflow_end got %b want %b", name, overflow, exp_ovf);
    end
    checks++;
    if (sdram_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s idle_end got req=%b busy=%b want 0 0", name, sdram_req, busy);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({sdram_req, busy, prog_done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL %s got req=%b busy=%b done=%b ovf=%b want 0 0 0 0",
               name, sdram_req, busy, prog_done, overflow);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_data = '0; sdram_ack = 1'b0;
    repeat (3) @(negedge clk_rom);
    check_quiet("reset_low");
    rst_n = 1'b1;
    @(negedge clk_rom);
    check_quiet("reset_release");
  endtask

  task automatic test_idle_ignore();
    ack_en = 1'b0; prev_held = 0; downloading = 1'b0;
    step(1, 0, 8'h55); step(1, 1, 8'h66); step(0, 0, 0); step(0, 0, 0);
    check_quiet("idle_ignore");
  endtask

  task automatic test_basic();
    q_addr = '{0, 1, 2, 3}; q_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = '{{21'd0, 16'h2211, 2'b00}, {21'd1, 16'h4433, 2'b00}};
    run_download("basic", 2, 0, 0, 1'b0);
  endtask

  task automatic test_odd_tail();
    int d[5];
    foreach (d[i]) d[i] = int'($urandom_range(255, 0));
    q_addr = '{0, 1, 2, 3, 4}; q_data = '{d[0], d[1], d[2], d[3], d[4]};
    exp_q = '{{21'd0, 8'(d[1]), 8'(d[0]), 2'b00}, {21'd1, 8'(d[3]), 8'(d[2]), 2'b00},
              {21'd2, 8'h00, 8'(d[4]), 2'b10}};
    run_download("odd_tail", 2, 0, 1, 1'b0);
  endtask

  task automatic test_no_merge();
    q_addr = '{6, 9}; q_data = '{8'hA6, 8'hB9};
    exp_q = '{{21'd3, 16'h00A6, 2'b10}, {21'd4, 16'hB900, 2'b01}};
    run_download("no_merge", 1, 0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    q_addr.delete(); q_data.delete();
    for (int i = 0; i < 12; i++) begin
      q_addr.push_back(i); q_data.push_back(int'($urandom_range(255, 0)));
    end
    build_exp();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    run_download("overflow", 1, 12, 1, 1'b1);
  endtask

  task automatic test_push_pop();
    q_addr = '{0, 1, 2, 3, 4, 5}; q_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_q = '{{21'd0, 16'h0201, 2'b00}, {21'd1, 16'h0403, 2'b00}, {21'd2, 16'h0605, 2'b00}};
    run_download("push_pop", 1, 5, 0, 1'b0);
  endtask

  task automatic test_random(input string name, input int base);
    int a;
    int n;
    q_addr.delete(); q_data.delete();
    a = base;
    n = int'($urandom_range(16, 3));
    for (int i = 0; i < n; i++) begin
      q_addr.push_back(a); q_data.push_back(int'($urandom_range(255, 0)));
      a += int'($urandom_range(3, 1));
    end
    build_exp();
    run_download(name, int'($urandom_range(2, 1)), 0, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0; prev_held = 0; wcnt = 0;
    downloading = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, i, i * 3);
    step(0, 0, 0); step(0, 0, 0);
    checks++;
    if (sdram_req !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL mid_queued got req=%b ovf=%b want 1 1", sdram_req, overflow);
    end
    @(negedge clk_rom);
    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; sdram_ack = 1'b0;
    #1;
    check_quiet("mid_reset_async");
    repeat (2) @(negedge clk_rom);
    check_quiet("mid_reset_hold");
    rst_n = 1'b1;
    prev_held = 0;
    test_random("after_reset", int'($urandom_range(1000, 0)));
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_odd_tail();
    test_no_merge();
    test_overflow();
    test_push_pop();
    for (int k = 0; k < 8; k++) test_random("random", int'($urandom_range(1 << 20, 0)));
    test_random("top_addr", (1 << AW) - 48);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
